// File: rtl/rv32v_dcache_port_arbiter_pkg.sv
// Shared types for the data-cache port arbiter: ownership, FSM state and
// a packed view of one cache request.
package rv32v_dcache_port_arbiter_pkg;

  localparam int WORD_W = 32;
  localparam int BE_W   = 4;

  typedef enum logic [1:0] {
    OWN_NONE,
    OWN_SCALAR,
    OWN_VECTOR
  } dcache_owner_t;

  typedef enum logic [1:0] {
    ARB_IDLE,
    ARB_S_BUSY,
    ARB_V_BUSY,
    ARB_V_DRAIN
  } arb_state_t;

  typedef struct packed {
    logic              ren;
    logic              wen;
    logic [WORD_W-1:0] addr;
    logic [WORD_W-1:0] wdata;
    logic [BE_W-1:0]   byte_ena;
  } cache_req_t;

  // Builds a cache request; a simultaneous read and write is issued as a write.
  function automatic cache_req_t make_req(
    input logic              ren,
    input logic              wen,
    input logic [WORD_W-1:0] addr,
    input logic [WORD_W-1:0] wdata,
    input logic [BE_W-1:0]   byte_ena
  );
    cache_req_t r;
    r.ren      = ren & ~wen;
    r.wen      = wen;
    r.addr     = addr;
    r.wdata    = wdata;
    r.byte_ena = byte_ena;
    return r;
  endfunction

endpackage

// File: rtl/rv32v_dcache_port_arbiter_if.sv
// One memory-port handshake bundle. The requester side uses the master
// modport, the responding side (cache, or the arbiter toward a requester)
// uses the slave modport.
interface rv32v_dcache_port_arbiter_if;
  import rv32v_dcache_port_arbiter_pkg::*;

  logic              ren;
  logic              wen;
  logic [WORD_W-1:0] addr;
  logic [WORD_W-1:0] wdata;
  logic [BE_W-1:0]   byte_ena;
  logic [WORD_W-1:0] rdata;
  logic              hit;

  modport master (
    output ren, wen, addr, wdata, byte_ena,
    input  rdata, hit
  );

  modport slave (
    input  ren, wen, addr, wdata, byte_ena,
    output rdata, hit
  );

endinterface

// File: rtl/rv32v_dcache_port_arbiter.sv
// Shares the single data-cache port between the scalar memory stage and the
// vector address scheduler. Ownership is locked from grant until d_hit; the
// vector side gets priority while v_lock is set, but after MAX_VEC_BURST
// vector completions with a scalar request waiting, the scalar side is served.
module rv32v_dcache_port_arbiter
  import rv32v_dcache_port_arbiter_pkg::*;
#(
  parameter int MAX_VEC_BURST = 4,
  parameter int CNT_W         = 4
) (
  input  logic                          CLK,
  input  logic                          nRST,
  rv32v_dcache_port_arbiter_if.slave    s,
  rv32v_dcache_port_arbiter_if.slave    v,
  rv32v_dcache_port_arbiter_if.master   d,
  input  logic                          v_lock,
  input  logic                          v_flush,
  output dcache_owner_t                 owner
);

  arb_state_t    state, state_nxt;
  logic [CNT_W-1:0] burst_cnt, burst_cnt_nxt;
  cache_req_t    s_req, v_req, v_held, d_req;
  dcache_owner_t grant;
  logic          s_pend, v_pend, burst_full;
  logic          s_hit, v_hit;

  // Scalar addresses are word aligned toward the cache.
  assign s_req = make_req(s.ren, s.wen, {s.addr[WORD_W-1:2], 2'b00}, s.wdata, s.byte_ena);
  assign v_req = make_req(v.ren, v.wen, v.addr, v.wdata, v.byte_ena);

  // A flushed vector request is invisible to arbitration.
  assign s_pend     = s.ren | s.wen;
  assign v_pend     = (v.ren | v.wen) & ~v_flush;
  assign burst_full = (burst_cnt >= CNT_W'(MAX_VEC_BURST));

  // State and burst counter registers.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state     <= ARB_IDLE;
      burst_cnt <= '0;
    end else begin
      state     <= state_nxt;
      burst_cnt <= burst_cnt_nxt;
    end
  end

  // Captures the granted vector request so a flushed access can drain with
  // stable address/data after the scheduler has withdrawn it.
  always_ff @(posedge CLK) begin
    if (state == ARB_IDLE && grant == OWN_VECTOR) begin
      v_held <= v_req;
    end
  end

  // Next state, grant, cache request mux and hit routing. Reset gates
  // everything off at once so outputs go quiet without waiting for a clock.
  always_comb begin
    state_nxt = state;
    grant     = OWN_NONE;
    d_req     = '0;
    s_hit     = 1'b0;
    v_hit     = 1'b0;
    if (nRST) begin
      case (state)
        ARB_IDLE: begin
          if (v_pend && (!s_pend || (v_lock && !burst_full))) begin
            grant = OWN_VECTOR;
            d_req = v_req;
            v_hit = d.hit;
            if (!d.hit) state_nxt = ARB_V_BUSY;
          end else if (s_pend) begin
            grant = OWN_SCALAR;
            d_req = s_req;
            s_hit = d.hit;
            if (!d.hit) state_nxt = ARB_S_BUSY;
          end
        end
        ARB_S_BUSY: begin
          grant = OWN_SCALAR;
          d_req = s_req;
          s_hit = d.hit & s_pend;
          if (d.hit) state_nxt = ARB_IDLE;
        end
        ARB_V_BUSY: begin
          grant = OWN_VECTOR;
          d_req = v_held;
          if (v_flush) begin
            state_nxt = d.hit ? ARB_IDLE : ARB_V_DRAIN;
          end else begin
            v_hit = d.hit & v_pend;
            if (d.hit) state_nxt = ARB_IDLE;
          end
        end
        ARB_V_DRAIN: begin
          grant = OWN_VECTOR;
          d_req = v_held;
          if (d.hit) state_nxt = ARB_IDLE;
        end
        default: state_nxt = ARB_IDLE;
      endcase
    end
  end

  // Burst counter: counts vector completions that overtook a waiting scalar.
  always_comb begin
    burst_cnt_nxt = burst_cnt;
    if (!v_lock || v_flush || s_hit) begin
      burst_cnt_nxt = '0;
    end else if (v_hit && s_pend && !burst_full) begin
      burst_cnt_nxt = burst_cnt + CNT_W'(1);
    end
  end

  assign d.ren      = d_req.ren;
  assign d.wen      = d_req.wen;
  assign d.addr     = d_req.addr;
  assign d.wdata    = d_req.wdata;
  assign d.byte_ena = d_req.byte_ena;

  assign s.rdata = d.rdata;
  assign v.rdata = d.rdata;
  assign s.hit   = s_hit;
  assign v.hit   = v_hit;
  assign owner   = grant;

endmodule

// File: tb/tb_rv32v_dcache_port_arbiter.sv
// Directed bench for the data-cache port arbiter.
module tb_rv32v_dcache_port_arbiter;
  import rv32v_dcache_port_arbiter_pkg::*;

  logic          CLK;
  logic          nRST;
  logic          v_lock;
  logic          v_flush;
  dcache_owner_t owner;
  int            total;
  int            bad;

  rv32v_dcache_port_arbiter_if s_bus ();
  rv32v_dcache_port_arbiter_if v_bus ();
  rv32v_dcache_port_arbiter_if d_bus ();

  rv32v_dcache_port_arbiter #(
    .MAX_VEC_BURST (4),
    .CNT_W         (4)
  ) dut (
    .CLK     (CLK),
    .nRST    (nRST),
    .s       (s_bus),
    .v       (v_bus),
    .d       (d_bus),
    .v_lock  (v_lock),
    .v_flush (v_flush),
    .owner   (owner)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic clear_inputs();
    s_bus.ren = 0; s_bus.wen = 0; s_bus.addr = '0; s_bus.wdata = '0; s_bus.byte_ena = '0;
    v_bus.ren = 0; v_bus.wen = 0; v_bus.addr = '0; v_bus.wdata = '0; v_bus.byte_ena = '0;
    d_bus.hit = 0; d_bus.rdata = '0;
    v_lock = 0; v_flush = 0;
  endtask

  initial begin
    logic exp_v;
    total = 0;
    bad   = 0;
    nRST  = 1'b0;
    clear_inputs();

    // reset: requests present but nothing reaches the cache
    #1;
    s_bus.ren = 1; s_bus.addr = 32'h100;
    #1;
    chk("rst_d_ren", 32'(d_bus.ren), 32'd0);
    chk("rst_d_wen", 32'(d_bus.wen), 32'd0);
    chk("rst_d_addr", d_bus.addr, 32'h0);
    chk("rst_s_hit", 32'(s_bus.hit), 32'd0);
    chk("rst_v_hit", 32'(v_bus.hit), 32'd0);
    chk("rst_owner", 32'(owner), 32'(OWN_NONE));
    s_bus.ren = 0; s_bus.addr = '0;
    tick();
    nRST = 1'b1;
    #1;
    chk("idle_owner", 32'(owner), 32'(OWN_NONE));
    chk("idle_d_addr", d_bus.addr, 32'h0);

    // scalar only, d_hit two cycles after grant; low address bits forced to 0
    tick();
    s_bus.ren = 1; s_bus.addr = 32'h103; s_bus.byte_ena = 4'hF;
    #1;
    chk("a_c0_d_ren", 32'(d_bus.ren), 32'd1);
    chk("a_c0_d_addr", d_bus.addr, 32'h100);
    chk("a_c0_owner", 32'(owner), 32'(OWN_SCALAR));
    chk("a_c0_s_hit", 32'(s_bus.hit), 32'd0);
    tick();
    chk("a_c1_d_addr", d_bus.addr, 32'h100);
    chk("a_c1_s_hit", 32'(s_bus.hit), 32'd0);
    tick();
    d_bus.hit = 1; d_bus.rdata = 32'hCAFEF00D;
    #1;
    chk("a_c2_s_hit", 32'(s_bus.hit), 32'd1);
    chk("a_c2_v_hit", 32'(v_bus.hit), 32'd0);
    chk("a_c2_s_rdata", s_bus.rdata, 32'hCAFEF00D);
    tick();
    clear_inputs();
    #1;
    chk("a_end_owner", 32'(owner), 32'(OWN_NONE));
    chk("a_end_d_ren", 32'(d_bus.ren), 32'd0);

    // both request, no vector lock, immediate hits: scalar then vector
    tick();
    s_bus.ren = 1; s_bus.addr = 32'h110;
    v_bus.ren = 1; v_bus.addr = 32'h210;
    d_bus.hit = 1;
    #1;
    chk("b_c0_owner", 32'(owner), 32'(OWN_SCALAR));
    chk("b_c0_s_hit", 32'(s_bus.hit), 32'd1);
    chk("b_c0_v_hit", 32'(v_bus.hit), 32'd0);
    chk("b_c0_d_addr", d_bus.addr, 32'h110);
    tick();
    s_bus.ren = 0;
    #1;
    chk("b_c1_owner", 32'(owner), 32'(OWN_VECTOR));
    chk("b_c1_v_hit", 32'(v_bus.hit), 32'd1);
    chk("b_c1_s_hit", 32'(s_bus.hit), 32'd0);
    chk("b_c1_d_addr", d_bus.addr, 32'h210);
    tick();
    clear_inputs();
    tick();

    // vector lock, both requesting continuously: four vector hits, one scalar
    v_lock = 1;
    s_bus.ren = 1; s_bus.addr = 32'h120;
    v_bus.wen = 1; v_bus.addr = 32'h220; v_bus.wdata = 32'hA5A5A5A5;
    d_bus.hit = 1;
    for (int i = 0; i < 10; i++) begin
      #1;
      exp_v = ((i % 5) != 4);
      chk("c_v_hit", 32'(v_bus.hit), 32'(exp_v));
      chk("c_s_hit", 32'(s_bus.hit), 32'(!exp_v));
      tick();
    end
    clear_inputs();
    tick();

    // vector granted, cache stalls; a scalar store arriving must not steal the port
    v_bus.ren = 1; v_bus.addr = 32'h200;
    #1;
    chk("d_c0_owner", 32'(owner), 32'(OWN_VECTOR));
    chk("d_c0_d_addr", d_bus.addr, 32'h200);
    tick();
    s_bus.wen = 1; s_bus.addr = 32'h300; s_bus.wdata = 32'h12345678; s_bus.byte_ena = 4'h3;
    for (int i = 0; i < 5; i++) begin
      #1;
      chk("d_hold_d_addr", d_bus.addr, 32'h200);
      chk("d_hold_d_wen", 32'(d_bus.wen), 32'd0);
      chk("d_hold_s_hit", 32'(s_bus.hit), 32'd0);
      tick();
    end
    d_bus.hit = 1;
    #1;
    chk("d_vdone_v_hit", 32'(v_bus.hit), 32'd1);
    chk("d_vdone_s_hit", 32'(s_bus.hit), 32'd0);
    tick();
    v_bus.ren = 0;
    #1;
    chk("d_s_owner", 32'(owner), 32'(OWN_SCALAR));
    chk("d_s_d_wen", 32'(d_bus.wen), 32'd1);
    chk("d_s_d_addr", d_bus.addr, 32'h300);
    chk("d_s_d_wdata", d_bus.wdata, 32'h12345678);
    chk("d_s_byte_ena", 32'(d_bus.byte_ena), 32'h3);
    chk("d_s_s_hit", 32'(s_bus.hit), 32'd1);
    tick();
    clear_inputs();
    tick();

    // flush while the vector owns the port: access drains, no v_hit, scalar next
    v_lock = 1;
    v_bus.ren = 1; v_bus.addr = 32'h400;
    s_bus.ren = 1; s_bus.addr = 32'h500;
    #1;
    chk("e_c0_owner", 32'(owner), 32'(OWN_VECTOR));
    chk("e_c0_d_addr", d_bus.addr, 32'h400);
    tick();
    v_flush = 1; v_bus.ren = 0; v_bus.addr = 32'hDEAD0000;
    #1;
    chk("e_c1_d_ren", 32'(d_bus.ren), 32'd1);
    chk("e_c1_d_addr", d_bus.addr, 32'h400);
    chk("e_c1_v_hit", 32'(v_bus.hit), 32'd0);
    tick();
    v_flush = 0;
    #1;
    chk("e_c2_d_ren", 32'(d_bus.ren), 32'd1);
    chk("e_c2_d_addr", d_bus.addr, 32'h400);
    tick();
    d_bus.hit = 1;
    #1;
    chk("e_c3_d_ren", 32'(d_bus.ren), 32'd1);
    chk("e_c3_v_hit", 32'(v_bus.hit), 32'd0);
    chk("e_c3_s_hit", 32'(s_bus.hit), 32'd0);
    tick();
    d_bus.hit = 0;
    #1;
    chk("e_c4_owner", 32'(owner), 32'(OWN_SCALAR));
    chk("e_c4_d_addr", d_bus.addr, 32'h500);
    d_bus.hit = 1;
    #1;
    chk("e_c4_s_hit", 32'(s_bus.hit), 32'd1);
    tick();
    clear_inputs();
    tick();

    // build up the burst count, then reset in the middle of a vector access
    v_lock = 1;
    s_bus.ren = 1; s_bus.addr = 32'h700;
    v_bus.ren = 1; v_bus.addr = 32'h600;
    d_bus.hit = 1;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("f_pre_v_hit", 32'(v_bus.hit), 32'd1);
      tick();
    end
    d_bus.hit = 0;
    #1;
    chk("f_grant_owner", 32'(owner), 32'(OWN_VECTOR));
    tick();
    chk("f_busy_owner", 32'(owner), 32'(OWN_VECTOR));
    chk("f_busy_d_ren", 32'(d_bus.ren), 32'd1);
    nRST = 0;
    d_bus.hit = 1;
    #1;
    chk("f_rst_d_ren", 32'(d_bus.ren), 32'd0);
    chk("f_rst_d_addr", d_bus.addr, 32'h0);
    chk("f_rst_v_hit", 32'(v_bus.hit), 32'd0);
    chk("f_rst_s_hit", 32'(s_bus.hit), 32'd0);
    chk("f_rst_owner", 32'(owner), 32'(OWN_NONE));
    tick();
    nRST = 1;
    for (int i = 0; i < 5; i++) begin
      #1;
      exp_v = (i != 4);
      chk("f_post_v_hit", 32'(v_bus.hit), 32'(exp_v));
      chk("f_post_s_hit", 32'(s_bus.hit), 32'(!exp_v));
      tick();
    end
    clear_inputs();
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
